cic_dec_ctrl: RTL and testbench

CIC_DEC_CTRL -- requirements
Module: cic_dec_ctrl

---
 rtl/cic_dec_ctrl.sv | 91 +++++++++
 tb/tb_cic_dec_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cic_dec_ctrl.sv
// Control sequencer for a CIC decimator: clears the datapath on start, gates the
// integrator and comb sections, suppresses warm-up outputs and flags lost outputs.
module cic_dec_ctrl #(
  parameter int WARMUP = 3,
  parameter int RW     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [RW-1:0] cfg_ratio,
  input  logic          start,
  input  logic          stop,
  input  logic          in_valid,
  input  logic          out_ready,
  output logic          dp_clr,
  output logic          integ_en,
  output logic          comb_en,
  output logic          out_valid,
  output logic          busy,
  output logic          overrun
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN} state_t;

  localparam int            WW       = (WARMUP < 2) ? 1 : $clog2(WARMUP + 1);
  localparam logic [WW-1:0] WARM_MAX = WW'(WARMUP);
  localparam logic [RW-1:0] R_MIN    = RW'(2);

  state_t        state, state_nxt;
  logic [RW-1:0] r_q;
  logic [RW-1:0] phase;
  logic [WW-1:0] warm_cnt;
  logic          accept;
  logic          warm_done;
  logic          phase_last;

  assign accept     = (state == S_IDLE) && start && !stop;
  assign warm_done  = (warm_cnt == WARM_MAX);
  assign phase_last = (phase == (r_q - RW'(1)));

  // Enables are decoded from the registered state, so asserting rst_n drops them at once.
  assign integ_en = (state == S_RUN) && in_valid && !stop;
  assign comb_en  = integ_en && phase_last;
  assign dp_clr   = (state == S_CLEAR);
  assign busy     = (state != S_IDLE);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && !stop) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_RUN;
      S_RUN:   if (stop) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      r_q       <= R_MIN;
      phase     <= '0;
      warm_cnt  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        r_q      <= (cfg_ratio < R_MIN) ? R_MIN : cfg_ratio;
        phase    <= '0;
        warm_cnt <= '0;
        overrun  <= 1'b0;
      end else if ((state == S_RUN) && stop) begin
        phase     <= '0;
        out_valid <= 1'b0;
      end else begin
        if (integ_en) phase <= phase_last ? '0 : phase + RW'(1);
        if (comb_en && !warm_done) warm_cnt <= warm_cnt + WW'(1);
        // A post-warm-up strobe always presents the newest sample; an unconsumed one is lost.
        if (comb_en && warm_done) begin
          out_valid <= 1'b1;
          if (out_valid && !out_ready) overrun <= 1'b1;
        end else if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Self-checking bench for cic_dec_ctrl: a sample-counting reference model pushes the
// expected outputs of every cycle to a scoreboard queue that is popped at the falling edge.
module tb_cic_dec_ctrl;

  localparam int WARMUP = 3;
  localparam int RW     = 8;

  typedef enum {M_IDLE, M_CLEAR, M_RUN} mstate_t;

  logic          clk;
  logic          rst_n;
  logic [RW-1:0] cfg_ratio;
  logic          start, stop, in_valid, out_ready;
  logic          dp_clr, integ_en, comb_en, out_valid, busy, overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Expected {dp_clr, integ_en, comb_en, out_valid, busy, overrun} per cycle.
  logic [5:0] sb[$];

  mstate_t m_st;
  int      m_r, m_samples, m_strobes;
  bit      m_ov, m_ovr;

  cic_dec_ctrl #(.WARMUP(WARMUP), .RW(RW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_ratio (cfg_ratio),
    .start     (start),
    .stop      (stop),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .dp_clr    (dp_clr),
    .integ_en  (integ_en),
    .comb_en   (comb_en),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", tag, got[5:0], exp[5:0]);
    end
  endtask

  function automatic logic [5:0] observed();
    return {dp_clr, integ_en, comb_en, out_valid, busy, overrun};
  endfunction

  task automatic model_reset();
    m_st      = M_IDLE;
    m_r       = 2;
    m_samples = 0;
    m_strobes = 0;
    m_ov      = 0;
    m_ovr     = 0;
    sb.delete();
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic step(input bit iv, input bit rdy, input bit st, input bit sp, input int cfg);
    bit ei, ec, post;
    in_valid  = iv;
    out_ready = rdy;
    start     = st;
    stop      = sp;
    cfg_ratio = cfg[RW-1:0];
    ei = (m_st == M_RUN) && iv && !sp;
    ec = ei && (((m_samples + 1) % m_r) == 0);
    sb.push_back({m_st == M_CLEAR, ei, ec, m_ov, m_st != M_IDLE, m_ovr});
    @(negedge clk);
    check($sformatf("cyc%0d", cyc), 32'(observed()), 32'(sb.pop_front()));
    case (m_st)
      M_IDLE: if (st && !sp) begin
        m_st      = M_CLEAR;
        m_r       = (cfg < 2) ? 2 : cfg;
        m_samples = 0;
        m_strobes = 0;
        m_ovr     = 0;
      end
      M_CLEAR: m_st = M_RUN;
      M_RUN: if (sp) begin
        m_st      = M_IDLE;
        m_samples = 0;
        m_ov      = 0;
      end else begin
        if (ei) m_samples++;
        post = ec && (m_strobes >= WARMUP);
        if (ec) m_strobes++;
        if (post) begin
          if (m_ov && !rdy) m_ovr = 1;
          m_ov = 1;
        end else if (m_ov && rdy) begin
          m_ov = 0;
        end
      end
      default: m_st = M_IDLE;
    endcase
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_ratio = '0;
    start     = 0;
    stop      = 0;
    in_valid  = 1;
    out_ready = 0;
    model_reset();
    #12;
    check("reset_outputs", 32'(observed()), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(2);

    // R=4, continuous input: strobes on samples 4, 8, 12, 16; first output after sample 16.
    step(0, 1, 1, 0, 4);
    for (int i = 0; i < 40; i++) step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 9);                 // start while running is ignored
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0);
    idle(3);

    // R=0 and R=1 both behave as R=2.
    for (int r = 0; r < 2; r++) begin
      step(0, 1, 1, 0, r);
      for (int i = 0; i < 14; i++) step(1, 1, 0, 0, 0);
      step(0, 1, 0, 1, 0);
      idle(1);
    end

    // R=3 with in_valid toggling: a strobe every 6 cycles.
    step(0, 1, 1, 0, 3);
    for (int i = 0; i < 40; i++) step(i % 2 == 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    idle(2);

    // R=2 with downstream stalled: overrun on second post-warm-up strobe, sticky after stop.
    step(0, 0, 1, 0, 2);
    for (int i = 0; i < 14; i++) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    idle(3);

    // start and stop together in IDLE: stays idle.
    step(0, 1, 1, 1, 5);
    idle(2);

    // Random in_valid / out_ready with R=5.
    step(0, 1, 1, 0, 5);
    for (int i = 0; i < 120; i++) step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    idle(1);

    // Reset mid-run with out_valid held high.
    step(0, 0, 1, 0, 2);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0);
    check("pre_rst_out_valid", 32'(out_valid), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst", 32'(observed()), 32'h0);
    model_reset();
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 2);
    for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
